spram_arbiter: RTL and testbench
================================

// Module: spram_arbiter
// PURPOSE
//  Shares one single-port RAM (DEPTH x DATA_W, registered read, 1-cycle latency) between two
//  requesters (m0, m1) using round-robin arbitration. After reset, an init sequencer writes
//  INIT_VAL to every address. Only then are requests granted. Sits between bus masters and the
//  single_port_ram macro (clk/we/addr/data/q).
// PARAMETERS
//  DATA_W    32     RAM word width
//  ADDR_W    10     RAM address width
//  DEPTH     1024   words cleared by init sequencer (<= 2**ADDR_W)
//  INIT_VAL  0      value written to every word during init
// PORTS
//  clk        in   1       single clock; all logic on posedge
//  rst        in   1       synchronous, active-high reset
//  m0_req     in   1       m0 request; held with we/addr/wdata until m0_gnt
//  m0_we      in   1       1=write, 0=read
//  m0_addr    in   ADDR_W  m0 address
//  m0_wdata   in   DATA_W  m0 write data
//  m0_gnt     out  1       m0 access issued to RAM this cycle
//  m0_rvalid  out  1       m0 read data valid (cycle after read grant)
//  m0_rdata   out  DATA_W  m0 read data
//  m1_*       -    -       identical set for requester 1
//  ram_we     out  1       to RAM we
//  ram_addr   out  ADDR_W  to RAM addr
//  ram_data   out  DATA_W  to RAM data
//  ram_q      in   DATA_W  from RAM q, valid one cycle after a read is issued
//  init_done  out  1       1 once init sweep finished
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=INIT, init counter=0, rr pointer=m0.
//    init_done=0, m*_rvalid=0. gnt and ram_* are combinational: gnt=0, ram_we=1, ram_addr=0,
//    ram_data=INIT_VAL.
//  - FSM INIT: each cycle, ram_we=1, ram_addr=cnt, ram_data=INIT_VAL, and cnt increments.
//    At cnt==DEPTH-1 the next state is RUN, and init_done=1 registered from then on.
//    INIT takes exactly DEPTH cycles. Requests are ignored during INIT (gnt=0).
//  - FSM RUN: each cycle, at most one grant, decided combinationally:
//      only one req    -> grant it (no bubble; back-to-back grants allowed)
//      both req        -> grant the requester the rr pointer names
//      after any grant -> pointer = the other requester
//  - Granted requester drives ram_we/ram_addr/ram_data in the same cycle, so the RAM captures
//    at that posedge. With no grant, ram_we=0 and addr/data hold their last value.
//  - Read granted in cycle N: m*_rvalid=1 in cycle N+1 only, with m*_rdata=ram_q.
//    rvalid pulses for exactly one cycle. Writes never raise rvalid.
//  - Read after write to the same address in the next cycle returns the new data.
//    RAM q during a write cycle is unspecified and is never forwarded.
//  - rdata holds its last value when rvalid=0.
//  - Reset mid-INIT or mid-RUN: the sweep is aborted and restarts from 0, a pending rvalid is
//    dropped, the pointer returns to m0 and init_done falls to 0.
//  - Requester protocol: addr, we and wdata must stay stable while req=1 and gnt=0.
//    Behaviour is undefined if they change.
//  - Address width: the init counter is ADDR_W+1 bits wide, so DEPTH=2**ADDR_W does not wrap
//    early.
// STRUCTURE
//  - Shared package spram_ctl_pkg: FSM state encoding (ST_INIT, ST_RUN) and default
//    DATA_W/ADDR_W/DEPTH constants.
//  - One sub-module, rr_arb2: 2-way round-robin arbiter (req[1:0] -> gnt[1:0], pointer
//    register, sync reset).
//  - Top level: init FSM/counter, RAM mux, rvalid/rdata pipeline register.
// TESTING
//  1. Release rst at t0 -> ram_we=1 for 1024 cycles with addr 0..1023, then init_done=1.
//     m0 then reads 0x005 -> rvalid next cycle, rdata=0.
//  2. m0 writes 0xDEADBEEF @0x3FF, then m1 reads 0x3FF next cycle -> m1_rvalid=1,
//     m1_rdata=0xDEADBEEF.
//  3. Both hold read req for 4 cycles after init -> gnt order m0,m1,m0,m1.
//     Each rvalid follows one cycle after its gnt.
//  4. m1 alone issues 8 consecutive reads of 0x000..0x007 (preloaded i*3)
//     -> m1_gnt=1 on all 8 cycles, rdata 0,3,..,21.
//  5. rst pulsed at init cnt=300 -> ram_addr restarts at 0, and init_done rises 1024 cycles
//     after release.
//  6. m0_req=1 throughout INIT -> m0_gnt=0 until init_done, then granted in the first RUN cycle.
//  7. rst during a read grant cycle -> m0_rvalid stays 0 on the next cycle.

Source files
------------

// File: rtl/spram_ctl_pkg.sv
// Shared definitions for the single-port RAM arbiter slice.
//   state_t      : controller state encoding (ST_INIT while clearing the RAM,
//                  ST_RUN while serving requesters)
//   DEF_*        : default geometry of the RAM macro this block sits in front of
package spram_ctl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DEPTH  = 1024;

endpackage

// File: rtl/spram_arbiter_rr_arb2.sv
// rr_arb2 - two-way round-robin arbiter.
//   clk  : clock
//   rst  : synchronous active-high reset (pointer back to requester 0)
//   req  : request vector, bit 0 = m0, bit 1 = m1
//   gnt  : one-hot (or zero) grant, combinational from req and the pointer
// The pointer names the requester that wins a tie; after any grant it moves
// to the other requester. A lone requester is always granted immediately.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || !ptr)) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (gnt[0]) begin
      ptr <= 1'b1;
    end else if (gnt[1]) begin
      ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/spram_arbiter.sv
// spram_arbiter - shares one single-port RAM (registered read, 1-cycle
// latency) between two requesters with round-robin arbitration. After reset
// the whole RAM is swept with INIT_VAL; requests are only granted afterwards.
//   clk, rst              : clock, synchronous active-high reset
//   mN_req/we/addr/wdata  : requester N access, held until mN_gnt
//   mN_gnt                : access issued to the RAM this cycle
//   mN_rvalid/rdata       : read data, one cycle after a read grant
//   ram_we/addr/data      : RAM macro write enable, address, write data
//   ram_q                 : RAM macro read data
//   init_done             : high once the clearing sweep has finished
module spram_arbiter
  import spram_ctl_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q,
  output logic              init_done
);

  // One extra bit so DEPTH == 2**ADDR_W is reachable without wrapping.
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  state_t            state;
  logic [ADDR_W:0]   cnt;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] data_hold;
  logic [1:0]        vld_p1;
  logic [DATA_W-1:0] rdata0_p1;
  logic [DATA_W-1:0] rdata1_p1;

  // ---- stage 0: init sweep / arbitration / RAM mux ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  assign req = (state == ST_RUN) ? {m1_req, m0_req} : 2'b00;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = addr_hold;
    ram_data = data_hold;
    if (state == ST_INIT) begin
      ram_we   = 1'b1;
      ram_addr = cnt[ADDR_W-1:0];
      ram_data = INIT_VAL;
    end else if (gnt[0]) begin
      ram_we   = m0_we;
      ram_addr = m0_addr;
      ram_data = m0_wdata;
    end else if (gnt[1]) begin
      ram_we   = m1_we;
      ram_addr = m1_addr;
      ram_data = m1_wdata;
    end
  end

  // Idle cycles replay the last address/data so the RAM pins stay quiet.
  always_ff @(posedge clk) begin
    addr_hold <= ram_addr;
    data_hold <= ram_data;
  end

  // ---- stage 1: read return ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 2'b00;
    end else begin
      vld_p1 <= gnt & {~m1_we, ~m0_we};
    end
  end

  // ram_q is only meaningful in the cycle after a read; capture it then so
  // rdata keeps showing the last returned word afterwards.
  always_ff @(posedge clk) begin
    if (vld_p1[0]) begin
      rdata0_p1 <= ram_q;
    end
    if (vld_p1[1]) begin
      rdata1_p1 <= ram_q;
    end
  end

  assign m0_rvalid = vld_p1[0];
  assign m1_rvalid = vld_p1[1];
  assign m0_rdata  = vld_p1[0] ? ram_q : rdata0_p1;
  assign m1_rdata  = vld_p1[1] ? ram_q : rdata1_p1;

endmodule

// File: tb/tb_spram_arbiter.sv
module tb_spram_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic              clk;
  logic              rst;
  logic              m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;
  logic              m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] ram_q;
  logic              init_done;

  int n_chk;
  int n_fail;

  spram_arbiter #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .INIT_VAL ('0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_q     (ram_q),
    .init_done (init_done)
  );

  // Behavioural single-port RAM with registered read.
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Leaves the bench in the first INIT cycle (cnt=0) with rst released.
  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_init_done", init_done, 0);
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_ram_we", ram_we, 1);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_data", ram_data, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m1_rvalid", m1_rvalid, 0);
  endtask

  // Walks the sweep from the current cycle; returns the number of INIT cycles
  // seen and how many of them deviated from the expected write pattern.
  task automatic wait_init(output int n, output int bad);
    n = 0;
    bad = 0;
    while (!init_done && n < 3000) begin
      if (ram_we !== 1'b1 || ram_addr !== n[ADDR_W-1:0] || ram_data !== '0 ||
          m0_gnt !== 1'b0 || m1_gnt !== 1'b0)
        bad++;
      n++;
      tick();
    end
  endtask

  initial begin
    int n, bad;
    logic [63:0] e;
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA5A5_0000 | i;
    repeat (3) @(negedge clk);

    // m0 holds a read of 0x005 through the whole sweep.
    m0_req = 1; m0_we = 0; m0_addr = 10'h005;
    do_reset();
    wait_init(n, bad);
    chk("init_cycles", n, 1024);
    chk("init_sweep_bad", bad, 0);
    chk("init_done_high", init_done, 1);
    chk("first_run_m0_gnt", m0_gnt, 1);
    chk("first_run_ram_we", ram_we, 0);
    chk("first_run_ram_addr", ram_addr, 10'h005);
    tick();
    m0_req = 0;
    #1;
    chk("rd5_m0_rvalid", m0_rvalid, 1);
    chk("rd5_m0_rdata", m0_rdata, 0);
    chk("rd5_m1_rvalid", m1_rvalid, 0);

    // m0 write 0x3FF, then m1 reads it straight back.
    tick();
    chk("rvalid_one_pulse", m0_rvalid, 0);
    m0_req = 1; m0_we = 1; m0_addr = 10'h3FF; m0_wdata = 32'hDEADBEEF;
    #1;
    chk("wr_m0_gnt", m0_gnt, 1);
    chk("wr_ram_we", ram_we, 1);
    chk("wr_ram_addr", ram_addr, 10'h3FF);
    chk("wr_ram_data", ram_data, 32'hDEADBEEF);
    tick();
    m0_req = 0;
    m1_req = 1; m1_we = 0; m1_addr = 10'h3FF;
    #1;
    chk("raw_m1_gnt", m1_gnt, 1);
    chk("raw_ram_we", ram_we, 0);
    chk("wr_no_rvalid", m0_rvalid, 0);
    tick();
    m1_req = 0;
    #1;
    chk("raw_m1_rvalid", m1_rvalid, 1);
    chk("raw_m1_rdata", m1_rdata, 32'hDEADBEEF);

    // Both read continuously; last grant went to m1 so m0 leads.
    tick();
    m0_req = 1; m0_we = 0; m0_addr = 10'h3FF;
    m1_req = 1; m1_we = 0; m1_addr = 10'h005;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      #1;
      chk("rr_m0_gnt", m0_gnt, (k % 2) == 0);
      chk("rr_m1_gnt", m1_gnt, (k % 2) == 1);
      if (k > 0) begin
        chk("rr_m0_rvalid", m0_rvalid, ((k - 1) % 2) == 0);
        chk("rr_m1_rvalid", m1_rvalid, ((k - 1) % 2) == 1);
        if ((k - 1) % 2 == 0) chk("rr_m0_rdata", m0_rdata, 32'hDEADBEEF);
        else chk("rr_m1_rdata", m1_rdata, 0);
      end
    end
    tick();
    m0_req = 0; m1_req = 0;
    #1;
    chk("rr_last_m1_rvalid", m1_rvalid, 1);
    chk("rr_last_m1_rdata", m1_rdata, 0);
    chk("rr_last_m0_rvalid", m0_rvalid, 0);

    // m1 alone: preload i*3 then read back-to-back.
    for (int i = 0; i < 8; i++) begin
      tick();
      m1_req = 1; m1_we = 1; m1_addr = 10'(i); m1_wdata = 32'(i * 3);
      #1;
      chk("pre_m1_gnt", m1_gnt, 1);
    end
    for (int j = 0; j <= 8; j++) begin
      tick();
      if (j < 8) begin
        m1_we = 0; m1_addr = 10'(j);
      end else begin
        m1_req = 0;
      end
      #1;
      if (j < 8) chk("seq_m1_gnt", m1_gnt, 1);
      if (j > 0) begin
        e = 64'((j - 1) * 3);
        chk("seq_m1_rvalid", m1_rvalid, 1);
        chk("seq_m1_rdata", m1_rdata, e);
      end
    end
    tick();
    chk("hold_m1_rvalid", m1_rvalid, 0);
    chk("hold_m1_rdata", m1_rdata, 21);
    chk("idle_ram_we", ram_we, 0);
    chk("idle_ram_addr", ram_addr, 10'h007);

    // Reset lands on a read grant: its rvalid must be dropped.
    tick();
    m0_req = 1; m0_we = 0; m0_addr = 10'h001;
    rst = 1;
    #1;
    chk("rstgnt_m0_gnt", m0_gnt, 1);
    tick();
    m0_req = 0;
    rst = 0;
    #1;
    chk("rstgnt_m0_rvalid", m0_rvalid, 0);
    chk("rstgnt_init_done", init_done, 0);
    chk("rstgnt_ram_we", ram_we, 1);
    chk("rstgnt_ram_addr", ram_addr, 0);

    // Abort the sweep at cnt=300 and check it restarts from 0.
    repeat (300) tick();
    chk("mid_init_addr", ram_addr, 300);
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("restart_addr", ram_addr, 0);
    chk("restart_init_done", init_done, 0);
    wait_init(n, bad);
    chk("reinit_cycles", n, 1024);
    chk("reinit_sweep_bad", bad, 0);
    chk("reinit_done", init_done, 1);
    chk("post_init_ram_we", ram_we, 0);
    chk("post_init_ram_addr", ram_addr, 10'h3FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
